// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the scoreboarded register file.
//   DATA_W_DEF / NUM_REGS_DEF : default register width and register count
//   busy_vec_t                : scoreboard vector at the default register count
//   num_regs_ok()             : true for the supported register counts
//                               (powers of two, 2..256)
package regfile_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 8;

    typedef logic [NUM_REGS_DEF-1:0] busy_vec_t;

    function automatic bit num_regs_ok(input int n);
        return (n >= 2) && (n <= 256) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Busy bits for the register file. A write clears the busy bit of its
//   target and a reserve sets the busy bit of its target. When both hit
//   the same register in one cycle, the set wins. wr_unres_o pulses for
//   one cycle after a write that landed on a register that was not busy.
//   With ZERO_REG=1, register 0 ignores writes and reserves, and its busy
//   bit is constant 0.
//
// Ports
//   clk_i, reset_ni     clock, asynchronous active-low reset
//   write_i             write strobe
//   write_addr_i        write target
//   reserve_i           reserve strobe
//   reserve_addr_i      reserve target
//   busy_o              busy vector, bit n is register n
//   write_en_o          write strobe after register-0 masking (combinational)
//   wr_unres_o          registered unreserved-write pulse
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                write_i,
    input  logic [ADDR_W-1:0]   write_addr_i,
    input  logic                reserve_i,
    input  logic [ADDR_W-1:0]   reserve_addr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                write_en_o,
    output logic                wr_unres_o
);

    localparam bit ZR = (ZERO_REG != 0);

    logic                wr_en;
    logic                rsv_en;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_q;
    logic                wr_unres_q;

    always_comb begin
        wr_en  = write_i   && !(ZR && (write_addr_i   == '0));
        rsv_en = reserve_i && !(ZR && (reserve_addr_i == '0));

        clr_vec = '0;
        set_vec = '0;
        if (wr_en) begin
            clr_vec[write_addr_i] = 1'b1;
        end
        if (rsv_en) begin
            set_vec[reserve_addr_i] = 1'b1;
        end

        // Set is applied after clear so a same-register reserve wins.
        busy_next = (busy_q & ~clr_vec) | set_vec;
        if (ZR) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q     <= '0;
            wr_unres_q <= 1'b0;
        end else begin
            busy_q     <= busy_next;
            wr_unres_q <= wr_en && !busy_q[write_addr_i];
        end
    end

    assign busy_o     = busy_q;
    assign write_en_o = wr_en;
    assign wr_unres_o = wr_unres_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with a busy scoreboard. It has two combinational read
//   ports (S and T) and one write port. A reserve port marks a register as
//   waiting for a pending result, and the next write to that register
//   clears the mark. Optional ZERO_REG=1 hardwires register 0 to zero and
//   keeps it never busy.
//
//   Build option: define REGFILE_BYPASS_EN to forward same-cycle write
//   data to a read port that addresses the register being written. In that
//   case the busy flag reads as its post-edge value. Without the macro,
//   reads show the stored values from before the edge.
//
// Parameters
//   DATA_W    register width
//   NUM_REGS  register count, power of two from 2 to 256
//   ADDR_W    address width, must satisfy NUM_REGS == 2**ADDR_W
//   ZERO_REG  1: register 0 reads as zero and ignores writes/reserves
//
// Ports
//   clk_i, reset_ni                clock, asynchronous active-low reset
//   write_i, write_addr_i,
//   write_data_i                   write port
//   reserve_i, reserve_addr_i      reserve port
//   rs_addr_i, rs_data_o, rs_busy_o  read port S
//   rt_addr_i, rt_data_o, rt_busy_o  read port T
//   busy_o                         busy vector, bit n is register n
//   wr_unres_o                     pulse after a write to a non-busy register
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                write_i,
    input  logic [ADDR_W-1:0]   write_addr_i,
    input  logic [DATA_W-1:0]   write_data_i,
    input  logic                reserve_i,
    input  logic [ADDR_W-1:0]   reserve_addr_i,
    input  logic [ADDR_W-1:0]   rs_addr_i,
    output logic [DATA_W-1:0]   rs_data_o,
    output logic                rs_busy_o,
    input  logic [ADDR_W-1:0]   rt_addr_i,
    output logic [DATA_W-1:0]   rt_data_o,
    output logic                rt_busy_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                wr_unres_o
);

    localparam bit ZR = (ZERO_REG != 0);

    if (!num_regs_ok(NUM_REGS) || (NUM_REGS != (1 << ADDR_W))) begin : g_param_err
        $error("regfile_sb: NUM_REGS must be a power of two in 2..256 equal to 2**ADDR_W");
    end

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_en;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .write_i        (write_i),
        .write_addr_i   (write_addr_i),
        .reserve_i      (reserve_i),
        .reserve_addr_i (reserve_addr_i),
        .busy_o         (busy),
        .write_en_o     (wr_en),
        .wr_unres_o     (wr_unres_o)
    );

    // wr_en is already masked for register 0, so with ZERO_REG=1 entry 0
    // keeps its reset value of zero.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_addr_i] <= write_data_i;
        end
    end

    function automatic logic [DATA_W-1:0] port_data(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] d;
        d = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (write_addr_i == addr)) begin
            d = write_data_i;
        end
`endif
        if (ZR && (addr == '0)) begin
            d = '0;
        end
        return d;
    endfunction

    function automatic logic port_busy(input logic [ADDR_W-1:0] addr);
        logic b;
        b = busy[addr];
`ifdef REGFILE_BYPASS_EN
        // A forwarded read shows busy as it will be after the edge. The
        // write clears it, unless a reserve on the same register sets it
        // again.
        if (wr_en && (write_addr_i == addr)) begin
            b = reserve_i && (reserve_addr_i == addr);
        end
`endif
        if (ZR && (addr == '0)) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        rs_data_o = port_data(rs_addr_i);
        rt_data_o = port_data(rt_addr_i);
        rs_busy_o = port_busy(rs_addr_i);
        rt_busy_o = port_busy(rt_addr_i);
    end

    assign busy_o = busy;

endmodule
